// File: rtl/register_file_masked.sv
// register_file_masked
//   DEPTH x WIDTH register file with one lane-masked write port and two
//   registered read ports. Reads are write-first: a read at the same edge as
//   a write or clear returns the post-update word. Out-of-range addresses
//   (possible when DEPTH is not a power of two) never alias: writes to them
//   are dropped and reads from them return zero.
//
// Ports
//   clock       rising-edge clock
//   reset_n     asynchronous active-low reset (words, read data, rd_valid)
//   clr         synchronous clear of every word, beats a same-cycle write
//   wr_en       write strobe
//   wr_addr     write address
//   wr_mask     lane write enables, bit i covers Data_in[i*LANE_W +: LANE_W]
//   Data_in     write data
//   rd_en       read strobe shared by both read ports
//   rd_addr_a   read address, port A
//   rd_addr_b   read address, port B
//   Data_out_a  registered read data, port A (holds while rd_en=0)
//   Data_out_b  registered read data, port B (holds while rd_en=0)
//   rd_valid    high for one cycle after each accepted read
module register_file_masked #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int LANE_W = 8
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          clr,
  input  logic                          wr_en,
  input  logic [$clog2(DEPTH)-1:0]      wr_addr,
  input  logic [WIDTH/LANE_W-1:0]       wr_mask,
  input  logic [WIDTH-1:0]              Data_in,
  input  logic                          rd_en,
  input  logic [$clog2(DEPTH)-1:0]      rd_addr_a,
  input  logic [$clog2(DEPTH)-1:0]      rd_addr_b,
  output logic [WIDTH-1:0]              Data_out_a,
  output logic [WIDTH-1:0]              Data_out_b,
  output logic                          rd_valid
);

  localparam int NLANES = WIDTH / LANE_W;
  localparam int ADDR_W = $clog2(DEPTH);
  // One extra bit so DEPTH itself is representable in the range compare.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem      [DEPTH];
  logic [WIDTH-1:0] mem_next [DEPTH];

  logic [WIDTH-1:0] rd_data_a_p0;
  logic [WIDTH-1:0] rd_data_b_p0;
  logic [WIDTH-1:0] rd_data_a_p1;
  logic [WIDTH-1:0] rd_data_b_p1;
  logic             vld_p1;

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return {1'b0, addr} < DEPTH_L;
  endfunction

  // Replace only the enabled lanes of old_word with new_word.
  function automatic logic [WIDTH-1:0] merge_lanes(
    input logic [WIDTH-1:0]  old_word,
    input logic [WIDTH-1:0]  new_word,
    input logic [NLANES-1:0] mask
  );
    logic [WIDTH-1:0] merged;
    merged = old_word;
    for (int i = 0; i < NLANES; i++) begin
      if (mask[i]) begin
        merged[i*LANE_W +: LANE_W] = new_word[i*LANE_W +: LANE_W];
      end
    end
    return merged;
  endfunction

  // Stage p0: post-edge image of the array. Reads are taken from this image,
  // which is what gives write-first bypass and clear-returns-zero for free.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_next[i] = mem[i];
    end
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_next[i] = '0;
      end
    end else if (wr_en && in_range(wr_addr)) begin
      mem_next[wr_addr] = merge_lanes(mem[wr_addr], Data_in, wr_mask);
    end
  end

  always_comb begin
    rd_data_a_p0 = '0;
    rd_data_b_p0 = '0;
    if (in_range(rd_addr_a)) begin
      rd_data_a_p0 = mem_next[rd_addr_a];
    end
    if (in_range(rd_addr_b)) begin
      rd_data_b_p0 = mem_next[rd_addr_b];
    end
  end

  // Stage p1: array state and registered read data.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= mem_next[i];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_a_p1 <= '0;
      rd_data_b_p1 <= '0;
      vld_p1       <= 1'b0;
    end else begin
      vld_p1 <= rd_en;
      if (rd_en) begin
        rd_data_a_p1 <= rd_data_a_p0;
        rd_data_b_p1 <= rd_data_b_p0;
      end
    end
  end

  assign Data_out_a = rd_data_a_p1;
  assign Data_out_b = rd_data_b_p1;
  assign rd_valid   = vld_p1;

endmodule
